seq_multiplier: RTL and testbench

Parametrised iterative shift-add multiplier: the successor to the fixed 16x16 combinational adder-tree multiplier. It trades area for latency by processing `BITS_PER_CYCLE` multiplier bits per clock and supports signed and unsigned operands per transaction. It sits on the datapath behind a valid/ready handshake, so producers and consumers can stall it.

---
 rtl/mul_pkg.sv | 29 ++
 rtl/mul_step.sv | 27 ++
 rtl/seq_multiplier.sv | 131 +++++++++++++
 tb/tb_seq_multiplier.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
// FSM state type and parameter-derived sizing helpers.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Number of BUSY iterations needed to consume the whole multiplier.
  function automatic int steps_f(input int width, input int bpc);
    return width / bpc;
  endfunction

  // Step counter width; never narrower than one bit.
  function automatic int cnt_w_f(input int width, input int bpc);
    int s;
    s = width / bpc;
    return (s > 1) ? $clog2(s) : 1;
  endfunction

  // Legal configuration: width of at least 2, digit size dividing width.
  function automatic bit cfg_ok(input int width, input int bpc);
    return (width >= 2) && (bpc >= 1) && (bpc <= width)
        && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: multiply a digit of the multiplier by the
// multiplicand, align it, and fold it into the running accumulator.
module mul_step
  import mul_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1,
  parameter int SHW            = 4
) (
  input  logic [WIDTH:0]          i_mcand,
  input  logic [BITS_PER_CYCLE-1:0] i_digit,
  input  logic [SHW-1:0]          i_shamt,
  input  logic [2*WIDTH:0]        i_acc,
  output logic [2*WIDTH:0]        o_acc
);

  localparam int AW = 2 * WIDTH + 1;

  logic [AW-1:0] w_prod;

  // Partial product of this digit, shifted into place and accumulated.
  always_comb begin
    w_prod = AW'(i_mcand) * AW'(i_digit);
    o_acc  = i_acc + (w_prod << i_shamt);
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative sign-magnitude shift-add multiplier behind valid/ready.
// Consumes BITS_PER_CYCLE multiplier bits per BUSY cycle.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y
);

  localparam int STEPS = steps_f(WIDTH, BITS_PER_CYCLE);
  localparam int CW    = cnt_w_f(WIDTH, BITS_PER_CYCLE);
  localparam int AW    = 2 * WIDTH + 1;
  localparam int SHW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (!cfg_ok(WIDTH, BITS_PER_CYCLE)) begin : g_bad_cfg
    $error("seq_multiplier: BITS_PER_CYCLE must divide WIDTH >= 2");
  end

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH:0]     r_mcand;
  logic [WIDTH:0]     r_mplier;
  logic               r_neg;
  logic [CW-1:0]      r_cnt;
  logic [AW-1:0]      r_acc;
  logic [2*WIDTH-1:0] r_y;

  logic               w_accept;
  logic               w_last;
  logic               w_a_flip;
  logic               w_b_flip;
  logic [WIDTH:0]     w_a_mag;
  logic [WIDTH:0]     w_b_mag;
  logic [SHW-1:0]     w_shamt;
  logic [AW-1:0]      w_acc_nxt;
  logic [2*WIDTH-1:0] w_y_fin;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == LAST);
  assign w_a_flip = is_signed && a[WIDTH-1];
  assign w_b_flip = is_signed && b[WIDTH-1];

  // Negation in WIDTH+1 bits so the most negative operand still fits.
  assign w_a_mag = w_a_flip ? -{1'b1, a} : {1'b0, a};
  assign w_b_mag = w_b_flip ? -{1'b1, b} : {1'b0, b};

  assign w_shamt = SHW'(int'(r_cnt) * BITS_PER_CYCLE);

  assign w_y_fin = r_neg ? -w_acc_nxt[2*WIDTH-1:0]
                         :  w_acc_nxt[2*WIDTH-1:0];

  assign y = r_y;

  mul_step #(
    .WIDTH         (WIDTH),
    .BITS_PER_CYCLE(BITS_PER_CYCLE),
    .SHW           (SHW)
  ) u_step (
    .i_mcand(r_mcand),
    .i_digit(r_mplier[BITS_PER_CYCLE-1:0]),
    .i_shamt(w_shamt),
    .i_acc  (r_acc),
    .o_acc  (w_acc_nxt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and handshake decodes of the current state.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = BUSY;
      end
      BUSY: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_y      <= '0;
    end else if (w_accept) begin
      r_mcand  <= w_a_mag;
      r_mplier <= w_b_mag;
      r_neg    <= w_a_flip ^ w_b_flip;
      r_cnt    <= '0;
      r_acc    <= '0;
    end else if (r_state == BUSY) begin
      r_acc    <= w_acc_nxt;
      r_mplier <= r_mplier >> BITS_PER_CYCLE;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) r_y <= w_y_fin;
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: 16-bit default instance against a
// transaction model, plus a WIDTH=8 sweep of BITS_PER_CYCLE 1/2/4/8.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                  nm, act, exp, cyc);
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [31:0] ref_mul(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic s, input int w);
    longint pa, pb, p;
    pa = longint'({48'd0, a});
    pb = longint'({48'd0, b});
    if (s && a[w-1]) pa = pa - (longint'(1) << w);
    if (s && b[w-1]) pb = pb - (longint'(1) << w);
    p = pa * pb;
    if (w < 16) p = p & ((longint'(1) << (2 * w)) - 1);
    return p[31:0];
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'hFFFF;
      2: return 16'h0000;
      3: return 16'h0001;
      4: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Default configuration DUT
  logic        rst16, iv16, ir16, s16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] y16;

  seq_multiplier u_dut16 (
    .clk(clk), .rst(rst16),
    .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .is_signed(s16),
    .out_valid(ov16), .out_ready(or16),
    .y(y16)
  );

  // WIDTH=8 sweep, shared inputs, always-ready consumers
  logic        rst8, iv8, s8;
  logic [7:0]  a8, b8;
  logic        ir8 [4];
  logic        ov8 [4];
  logic [15:0] y8  [4];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    seq_multiplier #(.WIDTH(8), .BITS_PER_CYCLE(1 << g)) u_dut (
      .clk(clk), .rst(rst8),
      .in_valid(iv8), .in_ready(ir8[g]),
      .a(a8), .b(b8), .is_signed(s8),
      .out_valid(ov8[g]), .out_ready(1'b1),
      .y(y8[g])
    );
  end

  // Transaction model of the 16-bit instance: 0 idle, 1 busy, 2 done
  int          m_ph = 0;
  int          m_left = 0;
  logic [31:0] m_exp = '0;
  logic [31:0] m_y = '0;

  always @(posedge clk or posedge rst16) begin
    if (rst16) begin
      m_ph <= 0; m_left <= 0; m_y <= '0; m_exp <= '0;
    end else begin
      case (m_ph)
        0: if (iv16) begin
          m_exp  <= ref_mul(a16, b16, s16, 16);
          m_left <= 16;
          m_ph   <= 1;
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_ph <= 2;
            m_y  <= m_exp;
          end
        end
        default: if (or16) m_ph <= 0;
      endcase
    end
  end

  int          t_acc8 = -50;
  logic [15:0] e8 = '0;
  int          seen8 [4] = '{-100, -100, -100, -100};

  // Per-cycle comparison of both DUT groups against expectations
  always @(negedge clk) begin
    chk("in_ready16", 64'(ir16), 64'(m_ph == 0));
    chk("out_valid16", 64'(ov16), 64'(m_ph == 2));
    chk("y16", 64'(y16), 64'(m_y));
    chk("excl16", 64'(ir16 && ov16), 64'(0));
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("excl8_bpc%0d", 1 << g),
          64'(ir8[g] && ov8[g]), 64'(0));
      if (ov8[g]) begin
        chk($sformatf("single8_bpc%0d", 1 << g),
            64'(seen8[g] == t_acc8), 64'(0));
        chk($sformatf("lat8_bpc%0d", 1 << g),
            64'(cyc - t_acc8), 64'(8 >> g));
        chk($sformatf("y8_bpc%0d", 1 << g), 64'(y8[g]), 64'(e8));
        seen8[g] = t_acc8;
      end
    end
  end

  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [31:0] exp,
                       input string nm, input int hold);
    int t0, k;
    k = 0;
    while (!ir16 && k < 50) begin @(negedge clk); k++; end
    chk({nm, "_ready"}, 64'(ir16), 64'(1));
    a16 = a; b16 = b; s16 = s; iv16 = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    iv16 = 1'b0; a16 = ~a; b16 = 16'($urandom); s16 = ~s;
    k = 0;
    while (!ov16 && k < 40) begin @(negedge clk); k++; end
    chk({nm, "_lat"}, 64'(cyc - t0), 64'(16));
    chk({nm, "_y"}, 64'(y16), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_y"}, 64'(y16), 64'(exp));
      chk({nm, "_hold_ir"}, 64'(ir16), 64'(0));
      iv16 = 1'(i % 2); a16 = 16'($urandom); b16 = 16'($urandom);
    end
    iv16 = 1'b0;
    or16 = 1'b1;
    @(negedge clk);
    or16 = 1'b0;
    chk({nm, "_ir_after"}, 64'(ir16), 64'(1));
    chk({nm, "_ov_after"}, 64'(ov16), 64'(0));
    chk({nm, "_y_kept"}, 64'(y16), 64'(exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k, nst;
    logic [31:0] r;
    rst16 = 0; rst8 = 0; iv16 = 0; iv8 = 0; or16 = 0;
    a16 = '0; b16 = '0; s16 = 0; a8 = '0; b8 = '0; s8 = 0;
    #1 rst16 = 1; rst8 = 1;
    #1;
    chk("rst_ir16", 64'(ir16), 64'(1));
    chk("rst_ov16", 64'(ov16), 64'(0));
    chk("rst_y16", 64'(y16), 64'(0));
    for (int g = 0; g < 4; g++) begin
      chk("rst_ir8", 64'(ir8[g]), 64'(1));
      chk("rst_ov8", 64'(ov8[g]), 64'(0));
      chk("rst_y8", 64'(y8[g]), 64'(0));
    end
    chk("pin_mix_s", 64'(ref_mul(16'hFFFD, 16'h0007, 1, 16)),
        64'(32'hFFFFFFEB));
    chk("pin_w8_min", 64'(ref_mul(16'h0080, 16'h0080, 1, 8)),
        64'(32'h4000));
    chk("pin_w8_neg", 64'(ref_mul(16'h00FF, 16'h0002, 1, 8)),
        64'(32'hFFFE));
    @(negedge clk);
    @(negedge clk);
    rst16 = 0; rst8 = 0;
    @(negedge clk);

    run16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "uns_max", 0);
    run16(16'h8000, 16'h8000, 1'b1, 32'h40000000, "sgn_min2", 0);
    run16(16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, "sgn_min_one", 0);
    run16(16'hFFFD, 16'h0007, 1'b1, 32'hFFFFFFEB, "mix_s", 0);
    run16(16'hFFFD, 16'h0007, 1'b0, 32'h0006FFEB, "mix_u_bp", 10);

    // Asynchronous reset five cycles into an operation
    a16 = 16'h1234; b16 = 16'h5678; s16 = 0; iv16 = 1;
    @(negedge clk);
    iv16 = 0;
    repeat (4) @(negedge clk);
    #2 rst16 = 1;
    #1;
    chk("midrst_ir", 64'(ir16), 64'(1));
    chk("midrst_ov", 64'(ov16), 64'(0));
    chk("midrst_y", 64'(y16), 64'(0));
    @(negedge clk);
    rst16 = 0;
    nst = 0;
    repeat (30) begin @(negedge clk); if (ov16) nst++; end
    chk("midrst_no_stale", 64'(nst), 64'(0));

    // Random traffic with random stalls, valid pulses while busy
    repeat (3000) begin
      @(negedge clk);
      iv16 = 1'($urandom_range(0, 1));
      a16 = rnd16(); b16 = rnd16();
      s16 = 1'($urandom_range(0, 1));
      or16 = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    iv16 = 0; or16 = 1;
    repeat (25) @(negedge clk);
    or16 = 0;

    // WIDTH=8 sweep
    for (int i = 0; i < 1000; i++) begin
      k = 0;
      while (!(ir8[0] && ir8[1] && ir8[2] && ir8[3]) && k < 30) begin
        @(negedge clk); k++;
      end
      a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'(i % 2);
      r = ref_mul({8'd0, a8}, {8'd0, b8}, s8, 8);
      e8 = r[15:0];
      t_acc8 = cyc + 1;
      iv8 = 1;
      @(negedge clk);
      iv8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = ~s8;
      k = 0;
      while (!(seen8[0] == t_acc8 && seen8[1] == t_acc8 &&
               seen8[2] == t_acc8 && seen8[3] == t_acc8) && k < 20) begin
        @(negedge clk); k++;
      end
      chk("sweep_all_done", 64'(k < 20), 64'(1));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
